// File: rtl/grp_accum_ctrl_if.sv
// Group-descriptor, accumulator-control and result handshake bundle for grp_accum_ctrl.
// master = the sequencer, slave = the PE / descriptor source / result consumer side.
interface grp_accum_ctrl_if #(
    parameter int ACC_EXP_WIDTH = 6,
    parameter int GRP_CNT_WIDTH = 8
);
    logic                     grp_valid;
    logic                     grp_ready;
    logic [ACC_EXP_WIDTH-1:0] grp_a_max_exp;
    logic                     acc_clr;
    logic                     acc_en;
    logic [2:0]               w_sig;
    logic [2:0]               bit_idx;
    logic [ACC_EXP_WIDTH-1:0] a_max_exp;
    logic [GRP_CNT_WIDTH-1:0] grp_cnt;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  grp_valid, grp_a_max_exp, out_ready,
        output grp_ready, acc_clr, acc_en, w_sig, bit_idx, a_max_exp, grp_cnt, out_valid
    );

    modport slave (
        output grp_valid, grp_a_max_exp, out_ready,
        input  grp_ready, acc_clr, acc_en, w_sig, bit_idx, a_max_exp, grp_cnt, out_valid
    );
endinterface

// File: rtl/grp_accum_ctrl.sv
// Sequencer for one bit-serial group accumulator: clear, then walk the weight bits
// MSB->LSB for each accepted activation group, then present the tile result.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; illegal config raises cfg_err
// CLEAR    | one-cycle accumulator clear, group counter reset
// WAIT_GRP | ready for the next group descriptor, accumulator holds
// ACCUM    | one weight bit per cycle, w_sig counting down to 0
// DONE     | final tile result valid until out_ready
module grp_accum_ctrl #(
    parameter int ACC_EXP_WIDTH = 6,
    parameter int GRP_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [2:0]               cfg_w_bits_i,
    input  logic [GRP_CNT_WIDTH-1:0] cfg_num_grp_i,
    input  logic                     abort_i,
    output logic                     busy_o,
    output logic                     cfg_err_o,
    grp_accum_ctrl_if.master         bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_WAIT_GRP = 3'd2,
        S_ACCUM    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [2:0]               W_ONE = 3'd1;
    localparam logic [GRP_CNT_WIDTH-1:0] G_ONE = {{(GRP_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [2:0]               w_bits_q, w_bits_d;
    logic [GRP_CNT_WIDTH-1:0] num_grp_q, num_grp_d;
    logic [GRP_CNT_WIDTH-1:0] grp_cnt_q, grp_cnt_d;
    logic [2:0]               w_sig_q, w_sig_d;
    logic [ACC_EXP_WIDTH-1:0] a_max_exp_q, a_max_exp_d;
    logic                     cfg_err_q, cfg_err_d;

    logic cfg_bad;
    logic last_bit;
    logic last_grp;
    logic grp_ready_c;
    logic acc_clr_c;
    logic acc_en_c;
    logic out_valid_c;

    assign cfg_bad  = (cfg_w_bits_i == 3'd0) || (cfg_num_grp_i == '0);
    assign last_bit = (w_sig_q == 3'd0);
    assign last_grp = (grp_cnt_q == (num_grp_q - G_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_bits_q    <= '0;
            num_grp_q   <= '0;
            grp_cnt_q   <= '0;
            w_sig_q     <= '0;
            a_max_exp_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            w_bits_q    <= w_bits_d;
            num_grp_q   <= num_grp_d;
            grp_cnt_q   <= grp_cnt_d;
            w_sig_q     <= w_sig_d;
            a_max_exp_q <= a_max_exp_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_bits_d    = w_bits_q;
        num_grp_d   = num_grp_q;
        grp_cnt_d   = grp_cnt_q;
        w_sig_d     = w_sig_q;
        a_max_exp_d = a_max_exp_q;
        cfg_err_d   = 1'b0;
        grp_ready_c = 1'b0;
        acc_clr_c   = 1'b0;
        acc_en_c    = 1'b0;
        out_valid_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        w_bits_d  = cfg_w_bits_i;
                        num_grp_d = cfg_num_grp_i;
                        state_d   = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                acc_clr_c = 1'b1;
                grp_cnt_d = '0;
                state_d   = S_WAIT_GRP;
            end
            S_WAIT_GRP: begin
                grp_ready_c = 1'b1;
                if (bus.grp_valid) begin
                    a_max_exp_d = bus.grp_a_max_exp;
                    w_sig_d     = w_bits_q - W_ONE;
                    state_d     = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_en_c = 1'b1;
                if (!last_bit) begin
                    w_sig_d = w_sig_q - W_ONE;
                end else begin
                    grp_cnt_d = grp_cnt_q + G_ONE;
                    if (last_grp) begin
                        state_d = S_DONE;
                    end else begin
                        // Accept the next descriptor on the last bit so groups run without a bubble.
                        grp_ready_c = 1'b1;
                        if (bus.grp_valid) begin
                            a_max_exp_d = bus.grp_a_max_exp;
                            w_sig_d     = w_bits_q - W_ONE;
                        end else begin
                            state_d = S_WAIT_GRP;
                        end
                    end
                end
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d   = S_IDLE;
            cfg_err_d = 1'b0;
        end
    end

    assign bus.grp_ready = grp_ready_c;
    assign bus.acc_clr   = acc_clr_c;
    assign bus.acc_en    = acc_en_c;
    assign bus.w_sig     = w_sig_q;
    assign bus.bit_idx   = w_sig_q;
    assign bus.a_max_exp = a_max_exp_q;
    assign bus.grp_cnt   = grp_cnt_q;
    assign bus.out_valid = out_valid_c;
    assign busy_o        = (state_q != S_IDLE);
    assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_grp_accum_ctrl.sv
// Scoreboard bench for grp_accum_ctrl: stimulus queues expected bit steps, tile results
// and config errors; a negedge monitor pops and compares whenever the DUT presents them.
module tb_grp_accum_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] cfg_w_bits;
    logic [7:0] cfg_num_grp;
    logic       abort;
    logic       busy;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    grp_accum_ctrl_if #(.ACC_EXP_WIDTH(6), .GRP_CNT_WIDTH(8)) bus ();

    grp_accum_ctrl #(.ACC_EXP_WIDTH(6), .GRP_CNT_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .cfg_w_bits_i  (cfg_w_bits),
        .cfg_num_grp_i (cfg_num_grp),
        .abort_i       (abort),
        .busy_o        (busy),
        .cfg_err_o     (cfg_err),
        .bus           (bus)
    );

    typedef struct {
        logic [2:0] w_sig;
        logic [5:0] exp;
        logic       rdy;
    } acc_t;

    acc_t acc_q[$];
    int   done_q[$];
    int   err_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT shows a bit step, a new result or a cfg error.
    initial begin
        acc_t e;
        logic prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (bus.acc_en) begin
                    if (acc_q.size() == 0) begin
                        chk("acc_en_unexpected", int'(bus.acc_en), 0);
                    end else begin
                        e = acc_q.pop_front();
                        chk("w_sig", int'(bus.w_sig), int'(e.w_sig));
                        chk("bit_idx", int'(bus.bit_idx), int'(e.w_sig));
                        chk("a_max_exp", int'(bus.a_max_exp), int'(e.exp));
                        chk("grp_ready_in_accum", int'(bus.grp_ready), int'(e.rdy));
                    end
                end
                if (bus.out_valid && !prev_ov) begin
                    if (done_q.size() == 0) begin
                        chk("out_valid_unexpected", int'(bus.out_valid), 0);
                    end else begin
                        chk("grp_cnt_at_done", int'(bus.grp_cnt), done_q.pop_front());
                        chk("acc_en_at_done", int'(bus.acc_en), 0);
                    end
                end
                prev_ov = bus.out_valid;
                if (cfg_err) begin
                    if (err_q.size() == 0) begin
                        chk("cfg_err_unexpected", int'(cfg_err), 0);
                    end else begin
                        chk("cfg_err_busy", int'(busy), err_q.pop_front());
                    end
                end
            end
        end
    end

    // One tile: w bits/group, n groups with exponents base, base+1, ...; gap = WAIT_GRP cycles
    // with grp_valid low before each later group; hold = DONE cycles with out_ready low.
    task automatic do_tile(input int w, input int n, input int base, input int gap, input int hold);
        int  g;
        int  cyc;
        int  bubbles;
        int  wait_cnt;
        bit  seen;
        bit  xfer;
        for (int gi = 0; gi < n; gi++) begin
            for (int b = w - 1; b >= 0; b--) begin
                acc_q.push_back('{w_sig: 3'(b), exp: 6'(base + gi), rdy: (b == 0 && gi != n - 1)});
            end
        end
        done_q.push_back(n);

        start             = 1'b1;
        cfg_w_bits        = 3'(w);
        cfg_num_grp       = 8'(n);
        bus.grp_valid     = 1'b1;
        bus.grp_a_max_exp = 6'(base);
        tick();
        start = 1'b0;
        chk("acc_clr_after_start", int'(bus.acc_clr), 1);
        chk("busy_after_start", int'(busy), 1);

        g = 0; cyc = 0; bubbles = 0; wait_cnt = 0; seen = 1'b0;
        while (!bus.out_valid && cyc < 300) begin
            xfer = bus.grp_valid && bus.grp_ready;
            if (bus.acc_en) seen = 1'b1;
            else if (seen) bubbles++;
            if (!bus.grp_valid && g < n && bus.grp_ready && !bus.acc_en) wait_cnt++;
            tick();
            cyc++;
            if (xfer) begin
                g++;
                if (g < n) begin
                    bus.grp_a_max_exp = 6'(base + g);
                    if (gap > 0) begin
                        bus.grp_valid = 1'b0;
                        wait_cnt = 0;
                    end
                end else begin
                    bus.grp_valid = 1'b0;
                end
            end else if (!bus.grp_valid && g < n && wait_cnt >= gap) begin
                bus.grp_valid = 1'b1;
            end
        end
        if (cyc >= 300) chk("tile_timeout", cyc, 0);
        chk("tile_latency", 1 + cyc, 3 + n * w + (gap > 0 ? (n - 1) * (gap + 1) : 0));
        chk("bubble_cycles", bubbles, (gap > 0 ? (n - 1) * (gap + 1) : 0));

        for (int i = 0; i < hold; i++) begin
            start      = 1'b1;
            cfg_w_bits = 3'd0;
            tick();
            chk("done_hold_out_valid", int'(bus.out_valid), 1);
            chk("done_hold_acc_en", int'(bus.acc_en), 0);
            chk("done_hold_busy", int'(busy), 1);
        end
        start         = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("idle_after_ready_busy", int'(busy), 0);
        chk("idle_after_ready_out_valid", int'(bus.out_valid), 0);
        chk("idle_after_ready_grp_ready", int'(bus.grp_ready), 0);
    endtask

    task automatic bad_cfg(input int w, input int n);
        err_q.push_back(0);
        start       = 1'b1;
        cfg_w_bits  = 3'(w);
        cfg_num_grp = 8'(n);
        tick();
        start = 1'b0;
        chk("cfg_err_pulse", int'(cfg_err), 1);
        chk("cfg_err_no_busy", int'(busy), 0);
        chk("cfg_err_no_clr", int'(bus.acc_clr), 0);
        tick();
        chk("cfg_err_one_cycle", int'(cfg_err), 0);
        chk("cfg_err_still_idle", int'(busy), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_acc_clr"}, int'(bus.acc_clr), 0);
        chk({tag, "_acc_en"}, int'(bus.acc_en), 0);
        chk({tag, "_grp_ready"}, int'(bus.grp_ready), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_w_sig"}, int'(bus.w_sig), 0);
        chk({tag, "_a_max_exp"}, int'(bus.a_max_exp), 0);
        chk({tag, "_grp_cnt"}, int'(bus.grp_cnt), 0);
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        cfg_w_bits        = 3'd0;
        cfg_num_grp       = 8'd0;
        abort             = 1'b0;
        bus.grp_valid     = 1'b0;
        bus.grp_a_max_exp = 6'd0;
        bus.out_ready     = 1'b0;
        #12;
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        do_tile(4, 1, 5, 0, 0);
        do_tile(2, 3, 1, 0, 0);
        do_tile(2, 3, 10, 3, 0);
        do_tile(3, 2, 20, 0, 5);

        bad_cfg(0, 2);
        bad_cfg(3, 0);
        start      = 1'b1;
        cfg_w_bits = 3'd0;
        abort      = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_masks_cfg_err", int'(cfg_err), 0);

        do_tile(7, 2, 62, 0, 1);
        do_tile(1, 4, 40, 1, 0);

        // Abort on the second bit of the first group.
        acc_q.push_back('{w_sig: 3'd3, exp: 6'd9, rdy: 1'b0});
        acc_q.push_back('{w_sig: 3'd2, exp: 6'd9, rdy: 1'b0});
        start             = 1'b1;
        cfg_w_bits        = 3'd4;
        cfg_num_grp       = 8'd2;
        bus.grp_valid     = 1'b1;
        bus.grp_a_max_exp = 6'd9;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort         = 1'b0;
        bus.grp_valid = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_acc_en", int'(bus.acc_en), 0);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        tick();
        chk("abort_stays_idle", int'(busy), 0);

        // Async reset in the middle of an ACCUM cycle.
        start             = 1'b1;
        cfg_w_bits        = 3'd3;
        cfg_num_grp       = 8'd1;
        bus.grp_valid     = 1'b1;
        bus.grp_a_max_exp = 6'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_reset_acc_en", int'(bus.acc_en), 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("midcycle_reset");
        #3 rst = 1'b0;
        bus.grp_valid = 1'b0;
        tick();

        do_tile(4, 1, 5, 0, 0);

        repeat (3) tick();
        chk("acc_q_drained", acc_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
